// File: rtl/periph_bus_master.sv
// periph_bus_master: single-outstanding initiator on the shared peripheral bus.
// Sequences setup / strobe (with wait states) / hold phases, then a response.
module periph_bus_master #(
  parameter int WAIT_STATES = 1,
  parameter int CNT_W       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic        busy,
  inout  wire  [63:0] data,
  output logic [31:0] address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  size
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept, misaligned, on_bus, last;

  function automatic logic [63:0] mask_w(
    input logic [63:0] v,
    input logic [1:0]  s
  );
    logic [63:0] r;
    case (s)
      2'b00:   r = {56'd0, v[7:0]};
      2'b01:   r = {48'd0, v[15:0]};
      2'b10:   r = {32'd0, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ext_r(
    input logic [63:0] v,
    input logic [1:0]  s,
    input logic        sg
  );
    logic [63:0] r;
    case (s)
      2'b00:   r = {{56{sg & v[7]}}, v[7:0]};
      2'b01:   r = {{48{sg & v[15]}}, v[15:0]};
      2'b10:   r = {{32{sg & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign req_ready = reset & (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign on_bus    = (state_q == S_SETUP) | (state_q == S_STROBE) |
                     (state_q == S_HOLD);
  assign last      = (cnt_q == CNT_W'(WAIT_STATES));

  // Bus outputs decode straight from state so reset clears them at once.
  assign address    = on_bus ? addr_q : 32'd0;
  assign size       = on_bus ? size_q : 2'd0;
  assign mem_write  = (state_q == S_STROBE) & wr_q;
  assign mem_read   = (state_q == S_STROBE) & ~wr_q;
  assign data       = (on_bus & wr_q) ? wdata_q : {64{1'bz}};
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = mask_w(req_wdata, req_size);
          size_d  = req_size;
          sgn_d   = req_signed;
          rdata_d = 64'd0;
          err_d   = misaligned;
          state_d = misaligned ? S_RESP : S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = S_HOLD;
          if (!wr_q) rdata_d = ext_r(data, size_q, sgn_q);
        end
      end
      S_HOLD: state_d = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 64'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: WAIT_STATES=1 and WAIT_STATES=0 instances,
// directed plus random transactions against an arithmetic reference model.
module tb_periph_bus_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rv[2], rw[2], rsg[2], rr[2];
  logic [31:0] ra[2];
  logic [63:0] rwd[2];
  logic [1:0]  rs[2];
  wire         rdy[2], rsv[2], rse[2], bsy[2], mrd[2], mwr[2];
  wire  [63:0] rrd[2];
  wire  [31:0] adr[2];
  wire  [1:0]  sz[2];
  wire  [63:0] data0, data1;
  wire  [63:0] bus[2];
  logic [63:0] rsp_val[2];
  logic        keep[2];
  int          ws_of[2] = '{1, 0};
  int          last_end[2] = '{-1, -1};

  // Responder drives during mem_read; otherwise a 0-keeper exposes any
  // master drive at times the bus should be released.
  assign data0 = mrd[0] ? rsp_val[0] : (keep[0] ? 64'd0 : {64{1'bz}});
  assign data1 = mrd[1] ? rsp_val[1] : (keep[1] ? 64'd0 : {64{1'bz}});
  assign bus[0] = data0;
  assign bus[1] = data1;

  periph_bus_master #(.WAIT_STATES(1), .CNT_W(4)) u0 (
    .clock(clk), .reset(rst_n),
    .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]), .req_size(rs[0]),
    .req_signed(rsg[0]), .resp_valid(rsv[0]), .resp_ready(rr[0]),
    .resp_rdata(rrd[0]), .resp_error(rse[0]), .busy(bsy[0]),
    .data(data0), .address(adr[0]), .mem_read(mrd[0]),
    .mem_write(mwr[0]), .size(sz[0])
  );

  periph_bus_master #(.WAIT_STATES(0), .CNT_W(4)) u1 (
    .clock(clk), .reset(rst_n),
    .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]), .req_size(rs[1]),
    .req_signed(rsg[1]), .resp_valid(rsv[1]), .resp_ready(rr[1]),
    .resp_rdata(rrd[1]), .resp_error(rse[1]), .busy(bsy[1]),
    .data(data1), .address(adr[1]), .mem_read(mrd[1]),
    .mem_write(mwr[1]), .size(sz[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] b,
                                             input int bits, input bit sg);
    logic [63:0] span, v;
    if (bits == 64) return b;
    span = 64'd1 << bits;
    v = b % span;
    if (sg && v >= span / 2) v = v - span;
    return v;
  endfunction

  always @(negedge clk) begin
    chk("strobe_exclusive_0", mrd[0] & mwr[0], 0);
    chk("strobe_exclusive_1", mrd[1] & mwr[1], 0);
  end

  task automatic do_txn(input int i, input bit w, input logic [31:0] a,
                        input logic [63:0] wd, input logic [1:0] s,
                        input bit sg, input int bp, input logic [63:0] bv);
    int bits, n, ns, first_s, last_s, k;
    logic [63:0] span, exp_bus, exp_rd;
    bit mis;
    bits = 8 << s;
    span = (bits == 64) ? 64'd0 : (64'd1 << bits);
    mis = (a % (bits / 8)) != 0;
    exp_bus = (bits == 64) ? wd : wd % span;
    exp_rd = (w || mis) ? 64'd0 : model_load(bv, bits, sg);
    rsp_val[i] = bv;
    keep[i] = !w;
    rr[i] = 1'b0;
    k = 0;
    while (!rdy[i] && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("req_ready", rdy[i], 1);
    rv[i] = 1'b1; rw[i] = w; ra[i] = a;
    rwd[i] = wd; rs[i] = s; rsg[i] = sg;
    @(posedge clk); #1;
    rv[i] = 1'b0;
    n = 1; ns = 0; first_s = -1; last_s = -1;
    while (!rsv[i] && n < 60) begin
      if (mrd[i] || mwr[i]) begin
        ns++;
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
        chk("strobe_dir", mwr[i], w);
      end
      chk("address", adr[i], a);
      chk("size", sz[i], s);
      if (w) chk("store_data", bus[i], exp_bus);
      else   chk("load_bus", bus[i], mrd[i] ? bv : 64'd0);
      @(posedge clk); #1; n++;
    end
    chk("latency", n, mis ? 1 : ws_of[i] + 4);
    chk("strobe_cycles", ns, mis ? 0 : ws_of[i] + 1);
    if (!mis && last_end[i] >= 0)
      chk("strobe_gap", (first_s - last_end[i] - 1) >= 3, 1);
    if (!mis) last_end[i] = last_s;
    chk("resp_rdata", rrd[i], exp_rd);
    chk("resp_error", rse[i], mis);
    keep[i] = 1'b1;
    #1;
    chk("bus_released", bus[i], 0);
    chk("addr_in_resp", adr[i], 0);
    rv[i] = 1'b1; rw[i] = ~w; ra[i] = $urandom;
    rs[i] = 2'($urandom_range(0, 3));
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", rsv[i], 1);
      chk("bp_rdata", rrd[i], exp_rd);
      chk("bp_error", rse[i], mis);
      chk("bp_ready_low", rdy[i], 0);
    end
    rr[i] = 1'b1;
    @(posedge clk); #1;
    rr[i] = 1'b0;
    chk("resp_cleared", rsv[i], 0);
    chk("idle_ready", rdy[i], 1);
    chk("new_req_ignored", bsy[i], 0);
    rv[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] a;
    logic [1:0] s;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; rw[i] = 0; rsg[i] = 0; rr[i] = 0;
      ra[i] = 0; rwd[i] = 0; rs[i] = 0;
      rsp_val[i] = 0; keep[i] = 1;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", bsy[i], 0);
      chk("rst_ready", rdy[i], 0);
      chk("rst_resp_valid", rsv[i], 0);
      chk("rst_rdata", rrd[i], 0);
      chk("rst_error", rse[i], 0);
      chk("rst_address", adr[i], 0);
      chk("rst_size", sz[i], 0);
      chk("rst_strobes", {mrd[i], mwr[i]}, 0);
      chk("rst_bus", bus[i], 0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", rdy[0], 1);

    do_txn(0, 1, 32'h8000_0004, 64'hDEAD_BEEF_1234_5678, 2'b10, 0, 0, 0);
    do_txn(0, 0, 32'h8000_0003, {$urandom, $urandom}, 2'b00, 1, 0,
           {$urandom, 24'h0, 8'hF3});
    do_txn(0, 0, 32'h8000_0003, {$urandom, $urandom}, 2'b00, 0, 0,
           {$urandom, 24'h0, 8'hF3});
    do_txn(0, 0, 32'h8000_0001, 64'd0, 2'b01, 0, 0, {$urandom, $urandom});
    do_txn(0, 0, 32'h8000_0008, 64'd0, 2'b11, 1, 3, {$urandom, $urandom});

    rsp_val[0] = 0; keep[0] = 0;
    rv[0] = 1; rw[0] = 1; ra[0] = 32'h8000_0010;
    rwd[0] = 64'hA5A5_5A5A_0F0F_F0F0; rs[0] = 2'b11; rsg[0] = 0;
    @(posedge clk); #1;
    rv[0] = 0;
    k = 0;
    while (!mwr[0] && k < 10) begin
      @(posedge clk); #1; k++;
    end
    chk("reach_strobe", mwr[0], 1);
    rst_n = 1'b0; keep[0] = 1'b1;
    #1;
    chk("mid_rst_write", mwr[0], 0);
    chk("mid_rst_bus", bus[0], 0);
    chk("mid_rst_busy", bsy[0], 0);
    chk("mid_rst_ready", rdy[0], 0);
    chk("mid_rst_address", adr[0], 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_ready", rdy[0], 1);
    do_txn(0, 0, 32'h8000_0020, {$urandom, $urandom}, 2'b11, 0, 0,
           {$urandom, $urandom});

    for (int t = 0; t < 3; t++)
      do_txn(1, 0, 32'h8000_0040 + 32'(t * 8), 64'd0, 2'b11, 0, 0,
             {$urandom, $urandom});

    for (int t = 0; t < 40; t++) begin
      int i;
      i = t % 2;
      s = 2'($urandom_range(0, 3));
      a = 32'h8000_0000 | ($urandom & 32'hFF);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 1);
      do_txn(i, 1'($urandom), a, {$urandom, $urandom}, s, 1'($urandom),
             $urandom_range(0, 2), {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
